// File: rtl/result_aggregator.sv
// Accumulates CHUNK_SIZE x CHUNK_SIZE partial tiles into a MAT_DIM x MAT_DIM matrix, then streams it out row-major.
// Define AGG_SATURATE_EN for unsigned saturating accumulation instead of wrap-around.
module result_aggregator #(
    parameter int WIDTH      = 16,
    parameter int CHUNK_SIZE = 2,
    parameter int TILES      = 2,
    localparam int TW        = (TILES > 1) ? $clog2(TILES) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      result_valid,
    input  logic [CHUNK_SIZE*CHUNK_SIZE-1:0][WIDTH-1:0] result,
    input  logic [TW-1:0]                             tile_row,
    input  logic [TW-1:0]                             tile_col,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [WIDTH-1:0]                          out_data,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      err
);
    localparam int MAT_DIM = CHUNK_SIZE * TILES;
    localparam int NELEM   = MAT_DIM * MAT_DIM;
    localparam int NTILE   = TILES * TILES;
    localparam int LE      = CHUNK_SIZE * CHUNK_SIZE;
    localparam int CW      = $clog2(TILES + 1);
    localparam int IW      = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam int TIW     = (NTILE > 1) ? $clog2(NTILE) : 1;

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] buf_q [NELEM];
    logic [CW-1:0]    cnt_q [NTILE];
    logic [IW-1:0]    idx_q;
    logic             err_q;

    logic             tile_ok;
    logic [TIW-1:0]   tile_id;
    logic             accept;
    logic             drop;
    logic             all_full;

    function automatic logic [WIDTH-1:0] acc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef AGG_SATURATE_EN
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH] ? '1 : s[WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    // Flat row-major address of local element k inside tile (tr, tc).
    function automatic logic [IW-1:0] elem_addr(input int tr, input int tc, input int k);
        return IW'((tr * CHUNK_SIZE + k / CHUNK_SIZE) * MAT_DIM + tc * CHUNK_SIZE + k % CHUNK_SIZE);
    endfunction

    always_comb begin
        tile_ok  = (int'(tile_row) < TILES) && (int'(tile_col) < TILES);
        tile_id  = tile_ok ? TIW'(int'(tile_row) * TILES + int'(tile_col)) : '0;
        accept   = result_valid && (state_q == COLLECT) && tile_ok && (cnt_q[tile_id] < CW'(TILES));
        drop     = result_valid && !accept;
        // Counts as they will be after this cycle's accept.
        all_full = 1'b1;
        for (int t = 0; t < NTILE; t++) begin
            if (int'(cnt_q[TIW'(t)]) + ((accept && TIW'(t) == tile_id) ? 1 : 0) != TILES)
                all_full = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NELEM; i++) buf_q[i] <= '0;
            for (int t = 0; t < NTILE; t++) cnt_q[t] <= '0;
        end else begin
            if (drop) err_q <= 1'b1;
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        for (int k = 0; k < LE; k++)
                            buf_q[elem_addr(int'(tile_row), int'(tile_col), k)] <=
                                acc(buf_q[elem_addr(int'(tile_row), int'(tile_col), k)], result[k]);
                        cnt_q[tile_id] <= cnt_q[tile_id] + CW'(1);
                        if (all_full) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx_q == IW'(NELEM - 1)) begin
                            state_q <= COLLECT;
                            idx_q   <= '0;
                            for (int i = 0; i < NELEM; i++) buf_q[i] <= '0;
                            for (int t = 0; t < NTILE; t++) cnt_q[t] <= '0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    // Outputs decode only state/index/buffer registers; out_ready never reaches out_data.
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == DRAIN);
    assign out_data  = out_valid ? buf_q[idx_q] : '0;
    assign out_last  = out_valid && (idx_q == IW'(NELEM - 1));
    assign err       = err_q;
endmodule

// File: tb/tb_result_aggregator.sv
// Directed + randomized bench for result_aggregator against a matrix-level reference model.
module tb_result_aggregator;
    localparam int W  = 16;
    localparam int CS = 2;
    localparam int T  = 2;
    localparam int MD = CS * T;
    localparam int NE = MD * MD;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     result_valid = 1'b0;
    logic [CS*CS-1:0][W-1:0]  result = '0;
    logic [0:0]               tile_row = '0;
    logic [0:0]               tile_col = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [W-1:0]             out_data;
    logic                     out_last;
    logic                     busy;
    logic                     err;

    int errors = 0;
    int checks = 0;

    // Reference model: the matrix itself, per-tile partial counts, sticky error, drain flag.
    int mat [MD][MD];
    int cnt [T][T];
    bit err_m;
    bit drain_m;

    result_aggregator #(.WIDTH(W), .CHUNK_SIZE(CS), .TILES(T)) dut (
        .clk(clk), .rst(rst), .result_valid(result_valid), .result(result),
        .tile_row(tile_row), .tile_col(tile_col), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int addm(input int a, input int b);
`ifdef AGG_SATURATE_EN
        return (a + b > 65535) ? 65535 : a + b;
`else
        return (a + b) % 65536;
`endif
    endfunction

    function automatic bit model_full();
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++)
                if (cnt[r][c] != T) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear(input bit clr_err);
        for (int r = 0; r < MD; r++) for (int c = 0; c < MD; c++) mat[r][c] = 0;
        for (int r = 0; r < T; r++) for (int c = 0; c < T; c++) cnt[r][c] = 0;
        drain_m = 1'b0;
        if (clr_err) err_m = 1'b0;
    endtask

    // Present one partial tile for one cycle; entered and left at #1 after a rising edge.
    task automatic send(input int r, input int c, input logic [CS*CS-1:0][W-1:0] v);
        result_valid = 1'b1;
        tile_row     = r[0:0];
        tile_col     = c[0:0];
        result       = v;
        if (!drain_m && cnt[r][c] < T) begin
            for (int k = 0; k < CS*CS; k++)
                mat[r*CS + k/CS][c*CS + k%CS] = addm(mat[r*CS + k/CS][c*CS + k%CS], int'(v[k]));
            cnt[r][c]++;
            drain_m = model_full();
        end else begin
            err_m = 1'b1;
        end
        @(posedge clk); #1;
        result_valid = 1'b0;
        chk("send_out_valid", out_valid, drain_m);
        chk("send_err", err, err_m);
    endtask

    function automatic logic [CS*CS-1:0][W-1:0] splat(input int x);
        logic [CS*CS-1:0][W-1:0] v;
        for (int k = 0; k < CS*CS; k++) v[k] = W'(x);
        return v;
    endfunction

    function automatic logic [CS*CS-1:0][W-1:0] rnd_tile();
        return {$urandom, $urandom};
    endfunction

    // mode 0: always ready, 1: random ready, 2: ready low 3 cycles at n=5.
    task automatic drain(input int mode, input bit inj, input int stop_n);
        int n = 0;
        int cyc = 0;
        int low = 0;
        while (n < stop_n && cyc < 500) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(n == 5 && low < 3);
            endcase
            result_valid = inj && (n == 8 || n == NE-1);
            if (result_valid) begin
                result   = rnd_tile();
                tile_row = 1'($urandom_range(0, 1));
                tile_col = 1'($urandom_range(0, 1));
                err_m    = 1'b1;
            end
            @(negedge clk);
            chk("drain_valid", out_valid, 1);
            chk("drain_busy", busy, 1);
            chk($sformatf("drain_data[%0d]", n), out_data, mat[n/MD][n%MD]);
            if (out_ready) begin
                chk($sformatf("drain_last[%0d]", n), out_last, (n == NE-1));
                n++;
            end else begin
                low++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        result_valid = 1'b0;
        out_ready    = 1'b0;
        if (n < stop_n) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: transfers %0d required %0d", n, stop_n);
        end
        if (n == NE) begin
            chk("post_out_valid", out_valid, 0);
            chk("post_busy", busy, 0);
            chk("post_err", err, err_m);
            model_clear(1'b0);
        end
    endtask

    initial begin
        model_clear(1'b1);

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic accumulate: ones then twos on every tile
        for (int p = 1; p <= 2; p++)
            for (int r = 0; r < T; r++)
                for (int c = 0; c < T; c++) send(r, c, splat(p));
        drain(0, 1'b0, NE);

        // Ordering with backpressure at n=5
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++)
                if (r == 0 && c == 1) begin
                    logic [CS*CS-1:0][W-1:0] v;
                    v[0] = 16'd1; v[1] = 16'd2; v[2] = 16'd3; v[3] = 16'd4;
                    send(r, c, v);
                    send(r, c, splat(0));
                end else begin
                    send(r, c, splat(0));
                    send(r, c, splat(0));
                end
        drain(2, 1'b0, NE);

        // Third partial to (0,0) during COLLECT, then drops during DRAIN
        send(0, 0, rnd_tile());
        send(0, 0, rnd_tile());
        send(0, 0, rnd_tile());
        for (int t = 1; t < T*T; t++) begin
            send(t / T, t % T, rnd_tile());
            send(t / T, t % T, rnd_tile());
        end
        drain(0, 1'b1, NE);

        // Overflow at tile (1,1) element 0 -> output n=10
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++)
                if (r == 1 && c == 1) begin
                    send(r, c, CS*CS*W'(0) | 64'h0000_0000_0000_FFFF);
                    send(r, c, 64'h0000_0000_0000_0002);
                end else begin
                    send(r, c, splat(0));
                    send(r, c, splat(0));
                end
        drain(0, 1'b0, NE);

        // Random tile orders with random ready
        for (int it = 0; it < 3; it++) begin
            int q[$];
            for (int t = 0; t < T*T; t++) begin q.push_back(t); q.push_back(t); end
            for (int i = q.size() - 1; i > 0; i--) begin
                int j, tmp;
                j = $urandom_range(0, i);
                tmp = q[i]; q[i] = q[j]; q[j] = tmp;
            end
            foreach (q[i]) send(q[i] / T, q[i] % T, rnd_tile());
            drain(1, 1'b1, NE);
        end

        // Reset in the middle of a drain
        for (int p = 0; p < 2; p++)
            for (int t = 0; t < T*T; t++) send(t / T, t % T, rnd_tile());
        drain(0, 1'b0, 5);
        #2 rst = 1'b0;
        #1;
        model_clear(1'b1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_err", err, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++)
            for (int t = 0; t < T*T; t++) send(t / T, t % T, splat(1));
        drain(0, 1'b0, NE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
